// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit adder/subtractor that ripples one CW-bit chunk per stage.
// Define ADDSUB_FLAGS_EN to add the registered signed-overflow (ovf) and zero outputs.
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int CW = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] CHUNK_ONES = {WIDTH{1'b1}} >> (WIDTH - CW);

    logic              advance;
    logic [STAGES-1:0] vld_pipe;
    logic [WIDTH-1:0]  b_cond;
    logic              c_first;

    // The whole pipe moves together; it only freezes when a result is waiting on the consumer.
    assign advance   = !vld_pipe[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES-1];
    assign b_cond    = b ^ {WIDTH{sub}};
    assign c_first   = sub | c_in;

    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= (vld_pipe << 1) | STAGES'(in_valid);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int RW = WIDTH - k * CW;
        localparam logic [WIDTH-1:0] MASK = CHUNK_ONES << (k * CW);

        // w_* carries finished sum chunks below k and untouched A chunks from k upward.
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_d;
        logic [WIDTH-1:0] w_q;
        logic [RW-1:0]    b_in;
        logic             c_prev;
        logic             c_q;
        logic             v_in;
        logic [CW:0]      chunk;

        if (k == 0) begin : g_head
            assign w_in   = a;
            assign b_in   = b_cond;
            assign c_prev = c_first;
            assign v_in   = in_valid;
        end else begin : g_body
            assign w_in   = g_stg[k-1].w_q;
            assign b_in   = g_stg[k-1].g_skew.b_q;
            assign c_prev = g_stg[k-1].c_q;
            assign v_in   = vld_pipe[k-1];
        end

        assign chunk = {1'b0, w_in[k*CW +: CW]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_prev};
        assign w_d   = (w_in & ~MASK) | (WIDTH'(chunk[CW-1:0]) << (k * CW));

        // Data only loads with a real beat, so s keeps the last result across bubbles.
        always_ff @(posedge clk) begin
            if (reset) begin
                w_q <= '0;
                c_q <= 1'b0;
            end else if (advance && v_in) begin
                w_q <= w_d;
                c_q <= chunk[CW];
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [RW-CW-1:0] b_q;
            always_ff @(posedge clk) begin
                if (reset)
                    b_q <= '0;
                else if (advance && v_in)
                    b_q <= b_in[RW-1:CW];
            end
        end
    end

    assign s     = g_stg[STAGES-1].w_q;
    assign c_out = g_stg[STAGES-1].c_q;

`ifdef ADDSUB_FLAGS_EN
    logic a_msb;
    logic b_msb;
    logic s_msb;

    // Operand MSBs reach the last stage inside the skew registers.
    assign a_msb = g_stg[STAGES-1].w_in[WIDTH-1];
    assign b_msb = g_stg[STAGES-1].b_in[CW-1];
    assign s_msb = g_stg[STAGES-1].chunk[CW-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (advance && g_stg[STAGES-1].v_in) begin
            ovf  <= (a_msb == b_msb) && (s_msb != a_msb);
            zero <= (g_stg[STAGES-1].w_d == '0);
        end
    end
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vectors on a 16-bit/4-stage unit, plus random
// sweeps of 8-bit units with 1, 2 and 8 stages against a reference model.
module tb_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;
`ifdef ADDSUB_FLAGS_EN
    logic        ovf;
    logic        zero;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   sweep_done = 0;
    logic sweep_go = 1'b0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk      (clk),
        .reset    (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out)
`ifdef ADDSUB_FLAGS_EN
        ,
        .ovf      (ovf),
        .zero     (zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1. Latency counts cycles from the accepting cycle
    // to the first cycle showing out_valid.
    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, input logic ts, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
        int lat;
        a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        #4;
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = ~tc; sub = ~ts;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        #4;
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(c_out), 32'(ec));
`ifdef ADDSUB_FLAGS_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
`endif
        @(posedge clk); #1;
    endtask

    initial begin : main
        int   i;
        int   k;
        int   stale;
        logic acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        chk("rst_inrdy", 32'(in_ready), 32'd1);
`ifdef ADDSUB_FLAGS_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
`endif
        rst = 1'b0;

        run_one("add_basic",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_one("add_ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_neg",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_one("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("sub_cin_ign", 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Stream a=b=i, consumer stalls in cycles 6..9 while beat 2 (s=4) is on the output.
        i = 0; k = 0; c_in = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 9);
            in_valid  = (i < 8);
            a = 16'(i); b = 16'(i);
            #4;
            if (cyc >= 6 && cyc <= 9) begin
                chk("bp_inrdy", 32'(in_ready), 32'd0);
                chk("bp_ovalid", 32'(out_valid), 32'd1);
                chk("bp_hold_s", 32'(s), 32'd4);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp_s", 32'(s), 32'(2 * k));
                chk("bp_cout", 32'(c_out), 32'd0);
                k++;
            end
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(k), 32'd8);

        // Three beats in flight, then reset together with a fresh input beat.
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; a = 16'(100 + j); b = 16'd1;
            #4;
            chk("mr_fill_inrdy", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #4;
        chk("mr_ovalid", 32'(out_valid), 32'd0);
        chk("mr_s", 32'(s), 32'd0);
        chk("mr_cout", 32'(c_out), 32'd0);
        chk("mr_inrdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(posedge clk); #5;
            if (out_valid) stale++;
        end
        chk("mr_stale", 32'(stale), 32'd0);

        sweep_go = 1'b1;
        for (int t = 0; t < 3000 && sweep_done < 3; t++) @(posedge clk);
        chk("sweep_done", 32'(sweep_done), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SG = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        logic       iv, ir, ov, orr, ci, sb, co;
        logic [7:0] aa, bb, ss;
`ifdef ADDSUB_FLAGS_EN
        logic       ovf_s, zero_s;
`endif

        addsub_pipe #(.WIDTH(8), .STAGES(SG)) u_sw (
            .clk      (clk),
            .reset    (rst),
            .in_valid (iv),
            .in_ready (ir),
            .a        (aa),
            .b        (bb),
            .c_in     (ci),
            .sub      (sb),
            .out_valid(ov),
            .out_ready(orr),
            .s        (ss),
            .c_out    (co)
`ifdef ADDSUB_FLAGS_EN
            ,
            .ovf      (ovf_s),
            .zero     (zero_s)
`endif
        );

        initial begin : sweep
            logic [7:0] q_s[$];
            logic       q_c[$];
            logic       q_o[$];
            int         q_cyc[$];
            int         q_st[$];
            int         sent, got, stalls, lat, r;
            logic       acc, rc, ro;
            logic [7:0] rs;
            iv = 1'b0; orr = 1'b1; aa = '0; bb = '0; ci = 1'b0; sb = 1'b0;
            sent = 0; got = 0; stalls = 0;
            wait (sweep_go);
            @(posedge clk); #1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (!iv && sent < 40 && $urandom_range(0, 3) != 0) begin
                    iv = 1'b1;
                    aa = 8'($urandom); bb = 8'($urandom);
                    ci = 1'($urandom); sb = 1'($urandom);
                end
                orr = ($urandom_range(0, 3) != 0);
                #4;
                if (ov && orr) begin
                    chk($sformatf("sw%0d_expected", SG), 32'(q_s.size() != 0), 32'd1);
                    if (q_s.size() != 0) begin
                        chk($sformatf("sw%0d_s", SG), 32'(ss), 32'(q_s.pop_front()));
                        chk($sformatf("sw%0d_cout", SG), 32'(co), 32'(q_c.pop_front()));
`ifdef ADDSUB_FLAGS_EN
                        chk($sformatf("sw%0d_ovf", SG), 32'(ovf_s), 32'(q_o[0]));
                        chk($sformatf("sw%0d_zero", SG), 32'(zero_s), 32'(ss == 8'd0));
`endif
                        void'(q_o.pop_front());
                        lat = cyc - q_cyc.pop_front();
                        // Every cycle the output sat stalled delays the beat by exactly one.
                        chk($sformatf("sw%0d_lat", SG), 32'(lat), 32'(SG + stalls - q_st.pop_front()));
                    end
                    got++;
                end
                if (ov && !orr) stalls++;
                acc = iv && ir;
                if (acc) begin
                    if (sb) begin
                        rs = aa - bb;
                        rc = (aa >= bb);
                        r  = int'($signed(aa)) - int'($signed(bb));
                    end else begin
                        {rc, rs} = 9'(aa) + 9'(bb) + 9'(ci);
                        r = int'($signed(aa)) + int'($signed(bb)) + int'(ci);
                    end
                    ro = (r > 127) || (r < -128);
                    q_s.push_back(rs); q_c.push_back(rc); q_o.push_back(ro);
                    q_cyc.push_back(cyc); q_st.push_back(stalls);
                    sent++;
                end
                @(posedge clk); #1;
                if (acc) iv = 1'b0;
            end
            chk($sformatf("sw%0d_count", SG), 32'(got), 32'd40);
            sweep_done++;
        end
    end

endmodule
